// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO pointer/access controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fifo_pkg;

  // Pointer width including the wrap bit; depth is half the pointer range.
  localparam int SIZE  = 4;
  localparam int DEPTH = 1 << (SIZE - 1);

  typedef logic [SIZE-1:0] ptr_t;
  typedef logic [SIZE-2:0] addr_t;

  // Reflected binary Gray code: adjacent values differ in exactly one bit,
  // including across the natural 2^SIZE wrap.
  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between the FIFO users and its controller.
// Latency: n/a (wiring only).
// Backpressure: wr_gnt/full and empty/rd_en carry all flow control.
interface fifo_ctrl_if;
  import fifo_pkg::*;

  logic       flush;
  logic [1:0] wr_req;
  logic [1:0] wr_gnt;
  logic       wr_sel;
  logic       wr_en;
  addr_t      wr_addr;
  logic       rd_req;
  logic       rd_en;
  addr_t      rd_addr;
  logic       rd_valid;
  ptr_t       w_pointer;
  ptr_t       r_pointer;
  logic       full;
  logic       empty;
  ptr_t       count;

  // Producers/consumer side: issues requests, observes grants and status.
  modport master (
    output flush, wr_req, rd_req,
    input  wr_gnt, wr_sel, wr_en, wr_addr, rd_en, rd_addr, rd_valid,
    input  w_pointer, r_pointer, full, empty, count
  );

  // Controller side.
  modport slave (
    input  flush, wr_req, rd_req,
    output wr_gnt, wr_sel, wr_en, wr_addr, rd_en, rd_addr, rd_valid,
    output w_pointer, r_pointer, full, empty, count
  );

endinterface

// File: rtl/fifo_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter for the shared RAM write port.
// Latency: combinational, grant in the same cycle as the request.
// Backpressure: block forces zero grant; losers simply hold their request.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       block,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       sel
);

  // Lone requester wins outright; on contention the producer not served last wins.
  always_comb begin
    gnt = 2'b00;
    sel = 1'b0;
    if (!block) begin
      unique case (req)
        2'b01: begin
          gnt = 2'b01;
          sel = 1'b0;
        end
        2'b10: begin
          gnt = 2'b10;
          sel = 1'b1;
        end
        2'b11: begin
          if (last) begin
            gnt = 2'b01;
            sel = 1'b0;
          end else begin
            gnt = 2'b10;
            sel = 1'b1;
          end
        end
        default: begin
          gnt = 2'b00;
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/access controller for the 8-entry FIFO: arbitration, RAM addressing, flags.
// Latency: grants/enables/addresses combinational; flags and count one cycle after access; rd_valid one cycle after rd_en.
// Backpressure: full withholds write grants, empty withholds rd_en; flush withholds both.
module fifo_ctrl
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  fifo_ctrl_if.slave bus
);

  ptr_t       wbin;
  ptr_t       rbin;
  logic       last;
  logic       rd_valid_q;

  logic       full;
  logic       empty;
  logic [1:0] gnt;
  logic       sel;
  logic       wr_en;
  logic       rd_en;

  // Flags depend only on the registered pointers, never on this cycle's requests,
  // so a read cannot open space for a same-cycle write and a write cannot feed
  // a same-cycle read.
  assign full  = (wbin[SIZE-1] != rbin[SIZE-1]) && (wbin[SIZE-2:0] == rbin[SIZE-2:0]);
  assign empty = (wbin == rbin);

  rr_arb2 u_arb (
    .req   (bus.wr_req),
    .block (full | bus.flush),
    .last  (last),
    .gnt   (gnt),
    .sel   (sel)
  );

  assign wr_en = |gnt;
  assign rd_en = bus.rd_req & ~empty & ~bus.flush;

  assign bus.wr_gnt    = gnt;
  assign bus.wr_sel    = sel;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = wbin[SIZE-2:0];
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rbin[SIZE-2:0];
  assign bus.rd_valid  = rd_valid_q;
  assign bus.w_pointer = bin2gray(wbin);
  assign bus.r_pointer = bin2gray(rbin);
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = wbin - rbin;

  // Pointer advance, round-robin history and read-data-valid pipeline.
  // last starts at 1 so producer 0 wins the first contention; flush keeps it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin       <= '0;
      rbin       <= '0;
      last       <= 1'b1;
      rd_valid_q <= 1'b0;
    end else if (bus.flush) begin
      wbin       <= '0;
      rbin       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wbin <= wbin + ptr_t'(1);
        last <= sel;
      end
      if (rd_en) begin
        rbin <= rbin + ptr_t'(1);
      end
      rd_valid_q <= rd_en;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: queue-based reference model plus directed vectors.
// Latency: model mirrors one-cycle flag/rd_valid update.
// Backpressure: stimulus honours grant-hold rules; dropped requests are exercised.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_ctrl_if bus ();

  fifo_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Gray code from its definition: each bit is the XOR of adjacent binary bits.
  function automatic logic [SIZE-1:0] gray_of(input int b);
    logic [SIZE-1:0] v;
    logic [SIZE-1:0] g;
    v = b[SIZE-1:0];
    g[SIZE-1] = v[SIZE-1];
    for (int i = 0; i < SIZE - 1; i++) g[i] = v[i] ^ v[i+1];
    return g;
  endfunction

  // Reference model: contents as a queue of RAM addresses, plus write/read
  // positions counted modulo 2^SIZE and the last-served producer.
  int mq[$];
  int wpos = 0;
  int rpos = 0;
  bit m_last = 1'b1;
  bit m_rdv = 1'b0;
  bit model_ok = 1'b0;

  initial begin : compare_proc
    logic [1:0] e_gnt;
    logic       e_sel;
    logic       e_rd_en;
    logic       e_full;
    logic       e_empty;
    logic       c_rst;
    logic       c_flush;
    forever begin
      @(negedge clk);
      c_rst   = rst;
      c_flush = bus.flush;
      e_full  = (mq.size() == DEPTH);
      e_empty = (mq.size() == 0);
      e_gnt   = 2'b00;
      e_sel   = 1'b0;
      if (!e_full && !c_flush) begin
        if (bus.wr_req == 2'b01) begin
          e_gnt = 2'b01;
        end else if (bus.wr_req == 2'b10) begin
          e_gnt = 2'b10; e_sel = 1'b1;
        end else if (bus.wr_req == 2'b11) begin
          if (m_last) e_gnt = 2'b01;
          else begin e_gnt = 2'b10; e_sel = 1'b1; end
        end
      end
      e_rd_en = bus.rd_req && !e_empty && !c_flush;
      if (model_ok) begin
        chk("m_wr_gnt",    bus.wr_gnt,    e_gnt);
        if (e_gnt != 2'b00) chk("m_wr_sel", bus.wr_sel, e_sel);
        chk("m_wr_en",     bus.wr_en,     (e_gnt != 2'b00));
        chk("m_wr_addr",   bus.wr_addr,   wpos % DEPTH);
        chk("m_rd_en",     bus.rd_en,     e_rd_en);
        chk("m_rd_addr",   bus.rd_addr,   rpos % DEPTH);
        if (e_rd_en) chk("m_rd_order", bus.rd_addr, mq[0]);
        chk("m_rd_valid",  bus.rd_valid,  m_rdv);
        chk("m_w_pointer", bus.w_pointer, gray_of(wpos));
        chk("m_r_pointer", bus.r_pointer, gray_of(rpos));
        chk("m_full",      bus.full,      e_full);
        chk("m_empty",     bus.empty,     e_empty);
        chk("m_count",     bus.count,     mq.size());
      end
      @(posedge clk);
      if (c_rst) begin
        mq.delete(); wpos = 0; rpos = 0; m_last = 1'b1; m_rdv = 1'b0;
        model_ok = 1'b1;
      end else if (c_flush) begin
        mq.delete(); wpos = 0; rpos = 0; m_rdv = 1'b0;
      end else begin
        if (e_gnt != 2'b00) begin
          mq.push_back(wpos % DEPTH);
          wpos = (wpos + 1) % (2 * DEPTH);
          m_last = e_sel;
        end
        if (e_rd_en) begin
          void'(mq.pop_front());
          rpos = (rpos + 1) % (2 * DEPTH);
        end
        m_rdv = e_rd_en;
      end
    end
  end

  // Called at posedge+1: apply inputs and move to negedge+1 for sampling.
  task automatic set_in(input logic [1:0] w, input logic r, input logic f);
    bus.wr_req = w;
    bus.rd_req = r;
    bus.flush  = f;
    #5;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    bus.wr_req = 2'b00; bus.rd_req = 1'b0; bus.flush = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [1:0]      exp_gnt[4];
  logic [SIZE-1:0] prev_wp;

  initial begin : main_proc
    bus.wr_req = 2'b00; bus.rd_req = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset then idle.
    set_in(2'b00, 1'b0, 1'b0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_wptr", bus.w_pointer, 4'b0000);
    chk("rst_rptr", bus.r_pointer, 4'b0000);
    chk("rst_rd_valid", bus.rd_valid, 0);
    tick();

    // Fill from producer 0.
    for (int i = 0; i < 8; i++) begin
      set_in(2'b01, 1'b0, 1'b0);
      chk("fill_gnt", bus.wr_gnt, 2'b01);
      chk("fill_addr", bus.wr_addr, i);
      tick();
    end
    set_in(2'b01, 1'b0, 1'b0);
    chk("full_flag", bus.full, 1);
    chk("full_count", bus.count, 8);
    chk("full_wptr", bus.w_pointer, 4'b1100);
    chk("full_rptr", bus.r_pointer, 4'b0000);
    chk("full_no_gnt", bus.wr_gnt, 2'b00);
    tick();

    // Full with simultaneous read and write: only the read goes.
    set_in(2'b01, 1'b1, 1'b0);
    chk("full_wptr_held", bus.w_pointer, 4'b1100);
    chk("fullrw_gnt", bus.wr_gnt, 2'b00);
    chk("fullrw_rd_en", bus.rd_en, 1);
    chk("fullrw_rd_addr", bus.rd_addr, 0);
    tick();
    set_in(2'b01, 1'b0, 1'b0);
    chk("fullrw_count7", bus.count, 7);
    chk("fullrw_rd_valid", bus.rd_valid, 1);
    chk("fullrw_full_clr", bus.full, 0);
    chk("fullrw_wr_gnt", bus.wr_gnt, 2'b01);
    chk("fullrw_wr_addr", bus.wr_addr, 0);
    tick();
    set_in(2'b00, 1'b0, 1'b0);
    chk("refill_count", bus.count, 8);
    chk("refill_full", bus.full, 1);
    tick();

    // Contention from reset alternates starting with producer 0.
    reset_dut();
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      set_in(2'b11, 1'b0, 1'b0);
      chk("cont_gnt", bus.wr_gnt, exp_gnt[i]);
      chk("cont_addr", bus.wr_addr, i);
      tick();
    end
    // Producer 1 drops its request ungranted-free: lone producer 0 wins.
    set_in(2'b01, 1'b0, 1'b0);
    chk("lone_gnt", bus.wr_gnt, 2'b01);
    tick();

    // Empty with simultaneous write and read: no fall-through.
    reset_dut();
    set_in(2'b10, 1'b1, 1'b0);
    chk("empty_wr_en", bus.wr_en, 1);
    chk("empty_wr_sel", bus.wr_sel, 1);
    chk("empty_rd_en", bus.rd_en, 0);
    tick();
    set_in(2'b00, 1'b1, 1'b0);
    chk("empty_next_rd_en", bus.rd_en, 1);
    chk("empty_next_rd_addr", bus.rd_addr, 0);
    chk("empty_next_count", bus.count, 1);
    tick();
    set_in(2'b00, 1'b0, 1'b0);
    chk("empty_rd_valid", bus.rd_valid, 1);
    chk("empty_again", bus.empty, 1);
    tick();

    // Wrap: 20 write/read pairs.
    reset_dut();
    prev_wp = 4'b0000;
    for (int p = 0; p < 20; p++) begin
      set_in(2'b01, 1'b0, 1'b0);
      chk("wrap_empty", bus.empty, 1);
      chk("wrap_count", bus.count, 0);
      tick();
      set_in(2'b00, 1'b1, 1'b0);
      chk("wrap_gray_step", $countones(bus.w_pointer ^ prev_wp), 1);
      prev_wp = bus.w_pointer;
      if (p == 14) chk("wrap_wptr_15", bus.w_pointer, 4'b1000);
      if (p == 15) chk("wrap_wptr_0", bus.w_pointer, 4'b0000);
      tick();
    end

    // Three writes, then flush with requests still asserted.
    for (int i = 0; i < 3; i++) begin
      set_in(2'b01, 1'b0, 1'b0);
      tick();
    end
    set_in(2'b11, 1'b1, 1'b1);
    chk("flush_count_pre", bus.count, 3);
    chk("flush_no_gnt", bus.wr_gnt, 2'b00);
    chk("flush_no_wr_en", bus.wr_en, 0);
    chk("flush_no_rd_en", bus.rd_en, 0);
    tick();
    set_in(2'b00, 1'b0, 1'b0);
    chk("flush_count", bus.count, 0);
    chk("flush_empty", bus.empty, 1);
    chk("flush_wptr", bus.w_pointer, 4'b0000);
    chk("flush_rd_valid", bus.rd_valid, 0);
    tick();

    // Reset mid-operation discards contents.
    set_in(2'b01, 1'b0, 1'b0);
    tick();
    set_in(2'b01, 1'b1, 1'b0);
    tick();
    reset_dut();
    set_in(2'b00, 1'b0, 1'b0);
    chk("midrst_count", bus.count, 0);
    chk("midrst_empty", bus.empty, 1);
    chk("midrst_rd_valid", bus.rd_valid, 0);
    tick();

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and access controller for the 8-entry FIFO datapath (SIZE=4). Two producers share the single RAM write port under round-robin arbitration; one consumer reads. The block owns the binary and Gray-coded write/read pointers and drives RAM addresses and enables. It also produces full, empty and occupancy, and exports the Gray pointers to downstream flag logic.

## Interface
- SIZE, 4, pointer width including wrap bit; depth = 2^(SIZE-1); minimum 3
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of both pointers
- wr_req  input  2  write request, bit i from producer i
- wr_gnt  output  2  one-hot (or zero) grant; write occurs this cycle
- wr_sel  output  1  index of granted producer, drives RAM data mux
- wr_en  output  1  RAM write enable (= |wr_gnt)
- wr_addr  output  SIZE-1  RAM write address
- rd_req  input  1  consumer read request
- rd_en  output  1  RAM read enable
- rd_addr  output  SIZE-1  RAM read address
- rd_valid  output  1  RAM read data valid, one cycle after rd_en
- w_pointer  output  SIZE  Gray-coded write pointer
- r_pointer  output  SIZE  Gray-coded read pointer
- full  output  1  FIFO full
- empty  output  1  FIFO empty
- count  output  SIZE  occupancy, 0..2^(SIZE-1)

## Operation
- State: wbin, rbin (SIZE-bit binary pointers), last (producer served last), rd_valid register.
- Address outputs: wr_addr = wbin[SIZE-2:0]; rd_addr = rbin[SIZE-2:0].
- Gray outputs: w_pointer = wbin ^ (wbin>>1), and likewise for r_pointer.
- Flags:
  - full when wbin[SIZE-1] != rbin[SIZE-1] and the low SIZE-1 bits are equal.
  - empty when wbin == rbin.
  - count = wbin - rbin, modulo 2^SIZE.
- Flags are functions of the current registered pointers only.
- Arbitration (combinational): no grant while full or flush.
  - Exactly one requester: it is granted.
  - Both request: grant !last.
  - last updates to wr_sel on every granted cycle.
- Write: wr_en=1 causes wbin <= wbin+1 (mod 2^SIZE) at the edge.
- Read: rd_en = rd_req & !empty & !flush; rd_en causes rbin <= rbin+1.
- Simultaneous read and write are both honoured in the same cycle.
- Full blocks writes even when a read occurs that cycle.
- Empty blocks reads even when a write occurs that cycle (no fall-through).
- Flush: wbin, rbin <= 0 and rd_valid <= 0; last is unchanged. Flush overrides all requests.
- Pointer wrap: the 2^SIZE wrap is natural modulo arithmetic; the Gray code stays single-bit-change across the wrap.

## Timing
- Reset values: wbin=rbin=0, so w_pointer=r_pointer=0, empty=1, full=0, count=0. Also last=1 (producer 0 wins the first contention) and rd_valid=0.
- rst overrides flush and all requests. Reset mid-operation discards contents with no drain.
- Grant, wr_en, rd_en and addresses are combinational from the current state and inputs; they are valid in the same cycle as the request.
- Flags and count update one cycle after the accepted access.
- rd_valid = rd_en registered: latency 1, matching the synchronous-read RAM.
- Throughput: one write and one read per cycle sustained.
- A producer holds wr_req until it sees wr_gnt. Dropping wr_req without a grant is legal and has no effect.

## Structure
- Package fifo_pkg:
  - default SIZE constant
  - function bin2gray(SIZE-bit)
  - localparam DEPTH = 1 << (SIZE-1)
- Sub-module rr_arb2: two-requester round-robin arbiter with inputs req[1:0], block, and the last register, producing gnt[1:0] and sel.
- fifo_ctrl instantiates rr_arb2, the pointers, flag logic and rd_valid register; roughly 150-200 lines total.

## Test plan
- Reset then idle: after rst, empty=1, full=0, count=0, w_pointer=r_pointer=4'b0000, rd_valid=0.
- Fill from producer 0, 8 writes: full=1 and count=8 after the 8th edge. w_pointer=4'b1100 (binary 8), r_pointer=4'b0000. A 9th wr_req gets wr_gnt=0 and wbin is unchanged.
- Contention: wr_req=2'b11 for 4 cycles from reset gives grants 01,10,01,10 and wr_addr 0,1,2,3.
- Full with simultaneous rd_req and wr_req: only the read is accepted. Count goes 8→7, rd_valid=1 the next cycle, and a write is granted the following cycle.
- Empty with simultaneous write and read: only the write is accepted and rd_en=0. On the next cycle rd_en=1 with rd_addr equal to the written address.
- Wrap and flush:
  - 20 write/read pairs: wbin wraps through 15→0 and w_pointer steps 4'b1000→4'b0000. Every step changes a single bit; empty stays 1 and count stays 0 between pairs.
  - Then 3 writes and flush: the next cycle shows count=0 and empty=1, and no grant is issued during the flush cycle.
